hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised hazard-control unit for the 5-stage MIPS pipeline.
- Detects load-use hazards and, when branches resolve in ID, branch-operand hazards. Generates PC/IF-ID write-enables, the IF/ID flush and the ID/EX control bubble.
- Adds multi-cycle stall sequencing for data memories with latency above one cycle, and a taken-branch/jump flush.
- Adds a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, total stall cycles per load-use hazard (1..15).
- BRANCH_IN_ID, 1, 1 = branch compares in ID (enables branch-operand hazards); 0 = disabled.
- CNT_W, 16, stall-counter width.

Ports:
- Clk  in  1  pipeline clock.
- Rst_n  in  1  asynchronous active-low reset.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_RegWrite  in  1  instruction in EX writes a register.
- EX_WriteReg  in  REG_AW  destination register of EX.
- MEM_MemRead  in  1  instruction in MEM is a load.
- MEM_WriteReg  in  REG_AW  destination register of MEM.
- ID_Rs  in  REG_AW  rs of the instruction in ID.
- ID_Rt  in  REG_AW  rt of the instruction in ID.
- ID_UseRs  in  1  ID instruction reads rs.
- ID_UseRt  in  1  ID instruction reads rt.
- ID_Branch  in  1  ID instruction is a conditional branch.
- ID_Taken  in  1  branch/jump in ID resolved taken.
- PC_Write  out  1  PC enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  clear IF/ID.
- IDEX_Bubble  out  1  zero ID/EX control fields.
- Stall_Cnt  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Reset, asynchronous while Rst_n=0:
  - FSM goes to IDLE and the counter clears.
  - Stall_Cnt=0, PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Source match: srcHit(r) = (r!=0) & ((ID_UseRs & ID_Rs==r) | (ID_UseRt & ID_Rt==r)). Register 0 never hazards.
- Hazard terms, evaluated combinationally in IDLE:
  - lu = EX_MemRead & srcHit(EX_WriteReg).
  - bh = BRANCH_IN_ID & ID_Branch & ((EX_RegWrite & srcHit(EX_WriteReg)) | (MEM_MemRead & srcHit(MEM_WriteReg))).
- stall = lu | bh in IDLE, or any cycle in HOLD.
- When stall=1:
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - IFID_Flush=0; ID_Taken is ignored because operands are stale.
- When stall=0 and ID_Taken=1: IFID_Flush=1 for that cycle; PC/IF-ID writes stay enabled.
- FSM has two states, IDLE and HOLD.
  - IDLE -> HOLD when lu=1 and LOAD_LAT>1; load rem=LOAD_LAT-1.
  - HOLD: stall asserted. rem decrements each cycle; on rem==1, HOLD -> IDLE.
  - In IDLE the next cycle re-evaluates hazards normally. A second stall is possible, e.g. the bh term triggering from MEM.
- bh never enters HOLD; it is a single-cycle stall, re-evaluated each cycle.
- Load-use latency:
  - LOAD_LAT=1 gives exactly 1 stall cycle, with zero-latency (same-cycle) assertion.
  - LOAD_LAT=N gives exactly N consecutive stall cycles.
- Stall_Cnt increments on every clock edge where stall=1 and saturates at all-ones.
- Reset mid-HOLD aborts the stall immediately; outputs return to reset values asynchronously.
- All outputs are combinational from state and inputs, except Stall_Cnt, which is registered.

Decomposition:
- Shared package hazard_pkg: state encoding (IDLE=1'b0, HOLD=1'b1), REG_AW default, and the zero-register constant.
- One natural sub-module: stall_counter (parametrised CNT_W saturating counter with enable and async active-low clear).
- Match logic stays inline.

Test Plan:
- Reset: hold Rst_n=0 with lu conditions present -> PC_Write=1, IFID_Write=1, IDEX_Bubble=0, Stall_Cnt=0.
- LOAD_LAT=1, load in EX: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_UseRs=1 -> stall for exactly 1 cycle, Stall_Cnt=1. Repeat with EX_WriteReg=0 -> no stall.
- LOAD_LAT=3, same hazard -> PC_Write=0 for exactly 3 consecutive cycles, then 1. Stall_Cnt=3.
- ID_UseRt=0 with ID_Rt=8 matching -> no stall.
- Branch in ID: ID_Branch=1, EX_RegWrite=1, EX_WriteReg=9, ID_Rt=9 -> 1-cycle stall.
  - Next cycle: MEM_MemRead=1, MEM_WriteReg=9 -> another stall.
  - Then ID_Taken=1 -> IFID_Flush=1 for 1 cycle.
- Taken during a stall: ID_Taken=1 while lu=1 -> IFID_Flush=0, IDEX_Bubble=1.
- Reset mid-HOLD (LOAD_LAT=4): assert Rst_n=0 after 2 stall cycles -> PC_Write=1 immediately; after release no residual stall.
- Saturation: CNT_W=3, force 9 stall cycles -> Stall_Cnt holds 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard-control unit: FSM encoding,
// default register-address width and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG   = 0;
  // Wide enough to hold LOAD_LAT-1 for the largest supported load latency (15).
  localparam int LAT_W      = 4;

endpackage

// File: rtl/stall_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard-control unit for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls, multi-cycle load stall sequencing, taken-branch flush and stall counting.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [REG_AW-1:0] EX_WriteReg,
  input  logic              MEM_MemRead,
  input  logic [REG_AW-1:0] MEM_WriteReg,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic              ID_Branch,
  input  logic              ID_Taken,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  localparam logic [LAT_W-1:0] HOLD_INIT = LAT_W'(LOAD_LAT - 1);
  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(ZERO_REG);

  state_t           state, state_nxt;
  logic [LAT_W-1:0] rem, rem_nxt;
  logic             ex_hit, mem_hit, lu, bh, stall_raw, stall;

  // Register 0 is hard-wired, so a write to it can never create a dependency.
  assign ex_hit  = (EX_WriteReg != REG_ZERO) &&
                   ((ID_UseRs && (ID_Rs == EX_WriteReg)) || (ID_UseRt && (ID_Rt == EX_WriteReg)));
  assign mem_hit = (MEM_WriteReg != REG_ZERO) &&
                   ((ID_UseRs && (ID_Rs == MEM_WriteReg)) || (ID_UseRt && (ID_Rt == MEM_WriteReg)));

  assign lu = EX_MemRead && ex_hit;
  assign bh = (BRANCH_IN_ID != 0) && ID_Branch &&
              ((EX_RegWrite && ex_hit) || (MEM_MemRead && mem_hit));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    stall_raw = 1'b0;
    unique case (state)
      IDLE: begin
        stall_raw = lu || bh;
        if (lu && (LOAD_LAT > 1)) begin
          state_nxt = HOLD;
          rem_nxt   = HOLD_INIT;
        end
      end
      HOLD: begin
        stall_raw = 1'b1;
        if (rem == LAT_W'(1)) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt = rem - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs must show reset values while reset is held, even with hazards on the inputs.
  assign stall       = Rst_n && stall_raw;
  assign PC_Write    = !stall;
  assign IFID_Write  = !stall;
  assign IDEX_Bubble = stall;
  // Branch operands are stale during a stall, so a taken resolution is ignored then.
  assign IFID_Flush  = Rst_n && !stall_raw && ID_Taken;

  stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (Clk),
    .rst_n(Rst_n),
    .en   (stall),
    .count(Stall_Cnt)
  );

endmodule
